// File: rtl/scoreboard_hazard_unit.sv
// Hazard/control unit for the 5-stage pipeline with variable-latency producers.
// A per-register countdown scoreboard stalls consumers of loads and MDU results,
// a unit-busy countdown serialises the non-pipelined MDU, a cache miss freezes the
// front end, and taken redirects from EX flush IF/ID and ID/EX.
module scoreboard_hazard_unit #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned RAW      = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MDU_LAT  = 4,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ValidD,
    input  logic [RAW-1:0]   rs1D,
    input  logic [RAW-1:0]   rs2D,
    input  logic             rs1UsedD,
    input  logic             rs2UsedD,
    input  logic [RAW-1:0]   rdD,
    input  logic             RegWriteD,
    input  logic             MemReadD,
    input  logic             MduD,
    input  logic             BranchE,
    input  logic             JumpE,
    input  logic             JalrE,
    input  logic             cond_trueE,
    input  logic             CacheStall,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int unsigned MAX_LAT = (LOAD_LAT > MDU_LAT) ? LOAD_LAT : MDU_LAT;
    localparam int unsigned CW      = (MAX_LAT < 1) ? 1 : $clog2(MAX_LAT + 1);
    localparam logic [CW-1:0] LOAD_V = CW'(LOAD_LAT);
    localparam logic [CW-1:0] MDU_V  = CW'(MDU_LAT);

    logic [CW-1:0]    r_cnt [NREGS];
    logic [CW-1:0]    r_mdu_cnt;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic             w_redirect;
    logic             w_raw_stall;
    logic             w_waw_stall;
    logic             w_mdu_stall;
    logic             w_dstall;
    logic             w_issue;
    logic             w_set_rd;
    logic [CW-1:0]    w_set_val;

    // Hazard detection from the current scoreboard state
    always_comb begin
        w_redirect  = (BranchE & cond_trueE) | JumpE | JalrE;
        w_raw_stall = ValidD & (
                      (rs1UsedD & (rs1D != '0) & (r_cnt[rs1D] != '0)) |
                      (rs2UsedD & (rs2D != '0) & (r_cnt[rs2D] != '0)));
        w_waw_stall = ValidD & RegWriteD & (rdD != '0) & (r_cnt[rdD] != '0);
        w_mdu_stall = ValidD & MduD & (r_mdu_cnt != '0);
        w_dstall    = w_raw_stall | w_waw_stall | w_mdu_stall;
        w_issue     = ValidD & ~CacheStall & ~w_redirect & ~w_dstall;
        w_set_rd    = w_issue & RegWriteD & (rdD != '0);
        if (MemReadD) begin
            w_set_val = LOAD_V;
        end else if (MduD) begin
            w_set_val = MDU_V;
        end else begin
            w_set_val = '0;
        end
    end

    // Pipeline control, priority: cache freeze, redirect, data/structural stall
    always_comb begin
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        IF_ID_Flush = 1'b0;
        ID_EX_Flush = 1'b0;
        if (CacheStall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
        end else if (w_redirect) begin
            IF_ID_Flush = 1'b1;
            ID_EX_Flush = 1'b1;
        end else if (w_dstall) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            ID_EX_Flush = 1'b1;
        end
    end

    // Per-register countdowns: load on issue, otherwise count down to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                r_cnt[r] <= '0;
            end
        end else if (!CacheStall) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                if (w_set_rd && (rdD == RAW'(r))) begin
                    r_cnt[r] <= w_set_val;
                end else if (r_cnt[r] != '0) begin
                    r_cnt[r] <= r_cnt[r] - CW'(1);
                end
            end
        end
    end

    // MDU busy countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mdu_cnt <= '0;
        end else if (!CacheStall) begin
            if (w_issue && MduD) begin
                r_mdu_cnt <= MDU_V;
            end else if (r_mdu_cnt != '0) begin
                r_mdu_cnt <= r_mdu_cnt - CW'(1);
            end
        end
    end

    // Saturating stall/redirect performance counters, frozen during cache stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!CacheStall) begin
            if (w_dstall && !w_redirect && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (w_redirect && (r_flush_cnt != '1)) begin
                r_flush_cnt <= r_flush_cnt + CNT_W'(1);
            end
        end
    end

    assign StallCount = r_stall_cnt;
    assign FlushCount = r_flush_cnt;

endmodule
